rom_route_sequencer: RTL and testbench

//  Sequences and shares one synchronous route ROM (1-cycle registered read) between two clients.

---
 rtl/rom_route_sequencer.sv | 168 ++++++++++++++++
 tb/tb_rom_route_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_route_sequencer.sv
// Shares one registered-read route ROM between a sequential stream client and a pipelined random-read client.
// Optional ROUTE_LOOP_EN: stream playback repeats until parar is asserted.
module rom_route_sequencer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    input  logic              parar,
    input  logic [ADDR_W-1:0] ultimo,
    output logic [DATA_W-1:0] s_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              s_fim,
    output logic              s_ativo,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_ack,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nx;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] last_nx;
    logic [DATA_W-1:0] s_data_nx;
    logic              s_valid_nx;
    logic              s_fim_nx;
    logic              prio_r;
    logic              r_pend;
    logic              conflict_c;
    logic              s_grant_c;
    logic              r_grant_c;

    // prio_r=1 means the random client wins the next conflict
    always_comb begin : arbiter
        conflict_c = (state == FETCH) && r_req;
        s_grant_c  = (state == FETCH) && (!r_req || !prio_r);
        r_grant_c  = r_req && ((state != FETCH) || prio_r);
    end

    assign r_ack = reset_n && r_grant_c;

    always_comb begin : rom_mux
        rom_address = '0;
        if (reset_n) begin
            if (s_grant_c) begin
                rom_address = ptr;
            end else if (r_grant_c) begin
                rom_address = r_addr;
            end
        end
    end

    always_comb begin : stream_next
        state_nx   = state;
        ptr_nx     = ptr;
        last_nx    = last;
        s_data_nx  = s_data;
        s_valid_nx = s_valid;
        s_fim_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (iniciar) begin
                    ptr_nx   = '0;
                    last_nx  = ultimo;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                if (s_grant_c) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                s_data_nx  = rom_data;
                s_valid_nx = 1'b1;
                state_nx   = HOLD;
            end
            HOLD: begin
                if (s_valid && s_ready) begin
                    s_valid_nx = 1'b0;
                    if (ptr == last) begin
                        s_fim_nx = 1'b1;
`ifdef ROUTE_LOOP_EN
                        ptr_nx   = '0;
                        state_nx = FETCH;
`else
                        state_nx = IDLE;
`endif
                    end else begin
                        ptr_nx   = ptr + ADDR_W'(1);
                        state_nx = FETCH;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
`ifdef ROUTE_LOOP_EN
        // stop overrides everything, including a final accept
        if (parar && (state != IDLE)) begin
            state_nx   = IDLE;
            s_valid_nx = 1'b0;
            s_fim_nx   = 1'b0;
        end
`endif
    end

`ifndef ROUTE_LOOP_EN
    logic unused_parar;
    assign unused_parar = parar;
`endif

    always_ff @(posedge clock or negedge reset_n) begin : stream_regs
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= '0;
            last    <= '0;
            s_data  <= '0;
            s_valid <= 1'b0;
            s_fim   <= 1'b0;
            s_ativo <= 1'b0;
            prio_r  <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            last    <= last_nx;
            s_data  <= s_data_nx;
            s_valid <= s_valid_nx;
            s_fim   <= s_fim_nx;
            s_ativo <= (state_nx != IDLE);
            if (conflict_c) begin
                prio_r <= ~prio_r;
            end
        end
    end

    // random-read pipeline: ack cycle -> ROM cycle -> result pulse
    always_ff @(posedge clock or negedge reset_n) begin : random_regs
        if (!reset_n) begin
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_pend  <= r_grant_c;
            r_valid <= r_pend;
            if (r_pend) begin
                r_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_route_sequencer.sv
// Self-checking bench for rom_route_sequencer with a registered-read ROM model and result scoreboards.
module tb_rom_route_sequencer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              iniciar;
    logic              parar;
    logic [ADDR_W-1:0] ultimo;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              s_fim;
    logic              s_ativo;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ack;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data = '0;

    logic [DATA_W-1:0] rom [16];
    logic [DATA_W-1:0] s_q [$];
    logic [DATA_W-1:0] r_q [$];
    logic              ack_d1;
    logic              ack_d2;
    logic              tb_prio;
    int                checks = 0;
    int                failures = 0;

    rom_route_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .iniciar     (iniciar),
        .parar       (parar),
        .ultimo      (ultimo),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_fim       (s_fim),
        .s_ativo     (s_ativo),
        .r_req       (r_req),
        .r_addr      (r_addr),
        .r_ack       (r_ack),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .rom_address (rom_address),
        .rom_data    (rom_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_address];

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; iniciar = 1'b0; parar = 1'b0; ultimo = '0; s_ready = 1'b0;
        r_req = 1'b1; r_addr = 4'd3;
        #2;
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
        checks++; if (s_data !== 4'h0) begin failures++; $display("FAIL reset_s_data got=%h exp=0", s_data); end
        checks++; if (s_fim !== 1'b0) begin failures++; $display("FAIL reset_s_fim got=%b exp=0", s_fim); end
        checks++; if (s_ativo !== 1'b0) begin failures++; $display("FAIL reset_s_ativo got=%b exp=0", s_ativo); end
        checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL reset_r_valid got=%b exp=0", r_valid); end
        checks++; if (r_data !== 4'h0) begin failures++; $display("FAIL reset_r_data got=%h exp=0", r_data); end
        checks++; if (r_ack !== 1'b0) begin failures++; $display("FAIL reset_r_ack got=%b exp=0", r_ack); end
        checks++; if (rom_address !== 4'h0) begin failures++; $display("FAIL reset_rom_address got=%h exp=0", rom_address); end
        r_req = 1'b0;
        #10 reset_n = 1'b1;
        tb_prio = 1'b0; ack_d1 = 1'b0; ack_d2 = 1'b0;
        cyc();
        checks++; if (s_ativo !== 1'b0) begin failures++; $display("FAIL reset_idle_ativo got=%b exp=0", s_ativo); end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] exp;
        logic last_acc;
        bit done;
        int n;
        s_ready = 1'b1; ultimo = 4'd2; iniciar = 1'b1;
`ifndef ROUTE_LOOP_EN
        parar = 1'b1;
`endif
        s_q.push_back(4'h0); s_q.push_back(4'hA); s_q.push_back(4'h2);
        cyc();
        iniciar = 1'b0;
        checks++; if (s_ativo !== 1'b1) begin failures++; $display("FAIL stream_ativo got=%b exp=1", s_ativo); end
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL stream_e0_valid got=%b exp=0", s_valid); end
        cyc();
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL stream_e1_valid got=%b exp=0", s_valid); end
        cyc();
        checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL stream_latency got=%b exp=1", s_valid); end
        done = 1'b0; n = 0;
        while (!done && n < 40) begin
            last_acc = 1'b0;
            if (s_valid) begin
                if (s_q.size() == 0) begin
                    checks++; failures++; $display("FAIL stream_extra_entry got=%h exp=none", s_data);
                    done = 1'b1;
                end else begin
                    exp = s_q.pop_front();
                    checks++; if (s_data !== exp) begin failures++; $display("FAIL stream_data got=%h exp=%h", s_data, exp); end
                    last_acc = (s_q.size() == 0);
                end
            end
            cyc(); n++;
            checks++; if (s_fim !== last_acc) begin failures++; $display("FAIL stream_fim got=%b exp=%b", s_fim, last_acc); end
            if (last_acc) begin
                checks++; if (s_ativo !== 1'b0) begin failures++; $display("FAIL stream_end_ativo got=%b exp=0", s_ativo); end
                done = 1'b1;
            end
        end
        if (!done) begin checks++; failures++; $display("FAIL stream_timeout got=%0d exp<40", n); end
        parar = 1'b0;
        s_q.delete();
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] exp;
        int n;
        s_ready = 1'b1; ultimo = 4'd3; iniciar = 1'b1;
        s_q.push_back(4'h0); s_q.push_back(4'hA); s_q.push_back(4'h2); s_q.push_back(4'h4);
        cyc();
        iniciar = 1'b0;
        n = 0; while (!s_valid && n < 10) begin cyc(); n++; end
        checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL stall_wait1 got=%b exp=1", s_valid); end
        exp = s_q.pop_front();
        checks++; if (s_data !== exp) begin failures++; $display("FAIL stall_first got=%h exp=%h", s_data, exp); end
        cyc();
        s_ready = 1'b0;
        n = 0; while (!s_valid && n < 10) begin cyc(); n++; end
        exp = s_q[0];
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (s_valid !== 1'b1 || s_data !== exp) begin failures++; $display("FAIL stall_hold got=%b/%h exp=1/%h", s_valid, s_data, exp); end
            checks++; if (rom_address !== 4'h0) begin failures++; $display("FAIL stall_rom_idle got=%h exp=0", rom_address); end
            cyc();
        end
        s_ready = 1'b1;
        exp = s_q.pop_front();
        checks++; if (s_data !== exp) begin failures++; $display("FAIL stall_release got=%h exp=%h", s_data, exp); end
        cyc();
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL stall_gap1 got=%b exp=0", s_valid); end
        cyc();
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL stall_gap2 got=%b exp=0", s_valid); end
        cyc();
        exp = s_q.pop_front();
        checks++; if (s_valid !== 1'b1 || s_data !== exp) begin failures++; $display("FAIL stall_resume got=%b/%h exp=1/%h", s_valid, s_data, exp); end
        cyc();
        n = 0; while (!s_valid && n < 10) begin cyc(); n++; end
        exp = s_q.pop_front();
        checks++; if (s_valid !== 1'b1 || s_data !== exp) begin failures++; $display("FAIL stall_last got=%b/%h exp=1/%h", s_valid, s_data, exp); end
        cyc();
        checks++; if (s_fim !== 1'b1) begin failures++; $display("FAIL stall_fim got=%b exp=1", s_fim); end
    endtask

    task automatic test_conflict();
        logic [DATA_W-1:0] exp;
        logic [ADDR_W-1:0] ptr_m;
        logic ack_now;
        int phase;
        int nxt;
        int n;
        s_ready = 1'b1; ultimo = 4'd3; iniciar = 1'b1; r_req = 1'b0;
        s_q.push_back(4'h0); s_q.push_back(4'hA); s_q.push_back(4'h2); s_q.push_back(4'h4);
        cyc();
        iniciar = 1'b0; r_req = 1'b1; r_addr = 4'd3;
        phase = 1; ptr_m = '0; ack_d1 = 1'b0; ack_d2 = 1'b0; n = 0;
        while (phase != 0 && n < 60) begin
            #1;
            ack_now = r_ack;
            nxt = phase;
            case (phase)
                1: begin
                    checks++; if (r_ack !== tb_prio) begin failures++; $display("FAIL conflict_grant got=%b exp=%b", r_ack, tb_prio); end
                    checks++; if (rom_address !== (tb_prio ? 4'd3 : ptr_m)) begin failures++; $display("FAIL conflict_addr got=%h exp=%h", rom_address, (tb_prio ? 4'd3 : ptr_m)); end
                    nxt = tb_prio ? 1 : 2;
                    tb_prio = ~tb_prio;
                end
                2: begin
                    checks++; if (r_ack !== 1'b1) begin failures++; $display("FAIL wait_r_grant got=%b exp=1", r_ack); end
                    nxt = 3;
                end
                default: begin
                    exp = s_q.pop_front();
                    checks++; if (s_valid !== 1'b1 || s_data !== exp) begin failures++; $display("FAIL conflict_s_data got=%b/%h exp=1/%h", s_valid, s_data, exp); end
                    if (ptr_m == 4'd3) nxt = 0;
                    else begin ptr_m = ptr_m + 4'd1; nxt = 1; end
                end
            endcase
            if (ack_now) r_q.push_back(rom[r_addr]);
            cyc(); n++;
            ack_d2 = ack_d1; ack_d1 = ack_now;
            checks++; if (r_valid !== ack_d2) begin failures++; $display("FAIL conflict_r_valid got=%b exp=%b", r_valid, ack_d2); end
            if (r_valid && r_q.size() != 0) begin
                exp = r_q.pop_front();
                checks++; if (r_data !== exp) begin failures++; $display("FAIL conflict_r_data got=%h exp=%h", r_data, exp); end
            end
            phase = nxt;
        end
        if (phase != 0) begin checks++; failures++; $display("FAIL conflict_timeout got=%0d exp<60", n); end
        r_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            ack_d2 = ack_d1; ack_d1 = 1'b0;
            checks++; if (r_valid !== ack_d2) begin failures++; $display("FAIL conflict_drain got=%b exp=%b", r_valid, ack_d2); end
            if (r_valid && r_q.size() != 0) begin
                exp = r_q.pop_front();
                checks++; if (r_data !== exp) begin failures++; $display("FAIL conflict_drain_data got=%h exp=%h", r_data, exp); end
            end
        end
        checks++; if (r_q.size() != 0) begin failures++; $display("FAIL conflict_r_pending got=%0d exp=0", r_q.size()); end
        r_q.delete(); s_q.delete();
    endtask

    task automatic test_r_burst();
        logic [DATA_W-1:0] exp;
        logic ack_now;
        ack_d1 = 1'b0; ack_d2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin r_req = 1'b1; r_addr = 4'(i + 1); end
            else r_req = 1'b0;
            #1;
            ack_now = r_ack;
            checks++; if (r_ack !== 1'(i < 3)) begin failures++; $display("FAIL burst_ack got=%b exp=%b", r_ack, 1'(i < 3)); end
            if (i < 3) begin
                checks++; if (rom_address !== r_addr) begin failures++; $display("FAIL burst_addr got=%h exp=%h", rom_address, r_addr); end
            end
            if (ack_now) r_q.push_back(rom[r_addr]);
            cyc();
            ack_d2 = ack_d1; ack_d1 = ack_now;
            checks++; if (r_valid !== ack_d2) begin failures++; $display("FAIL burst_r_valid got=%b exp=%b", r_valid, ack_d2); end
            if (r_valid && r_q.size() != 0) begin
                exp = r_q.pop_front();
                checks++; if (r_data !== exp) begin failures++; $display("FAIL burst_r_data got=%h exp=%h", r_data, exp); end
            end
        end
        checks++; if (r_data !== 4'h4) begin failures++; $display("FAIL burst_r_hold got=%h exp=4", r_data); end
        r_q.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        s_ready = 1'b0; ultimo = 4'd3; iniciar = 1'b1;
        cyc();
        iniciar = 1'b0;
        n = 0; while (!s_valid && n < 10) begin cyc(); n++; end
        checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL rmid_hold got=%b exp=1", s_valid); end
        #2;
        reset_n = 1'b0; r_req = 1'b1; r_addr = 4'd2;
        #1;
        checks++; if (s_valid !== 1'b0 || s_ativo !== 1'b0) begin failures++; $display("FAIL rmid_stream got=%b/%b exp=0/0", s_valid, s_ativo); end
        checks++; if (s_data !== 4'h0 || r_data !== 4'h0) begin failures++; $display("FAIL rmid_data got=%h/%h exp=0/0", s_data, r_data); end
        checks++; if (r_ack !== 1'b0 || rom_address !== 4'h0) begin failures++; $display("FAIL rmid_rom got=%b/%h exp=0/0", r_ack, rom_address); end
        r_req = 1'b0;
        #1 reset_n = 1'b1;
        tb_prio = 1'b0; ack_d1 = 1'b0; ack_d2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (s_fim !== 1'b0 || s_valid !== 1'b0 || r_valid !== 1'b0) begin failures++; $display("FAIL rmid_quiet got=%b/%b/%b exp=0/0/0", s_fim, s_valid, r_valid); end
        end
        s_ready = 1'b1; ultimo = 4'd0; iniciar = 1'b1;
        cyc();
        iniciar = 1'b0;
        n = 0; while (!s_valid && n < 10) begin cyc(); n++; end
        checks++; if (s_valid !== 1'b1 || s_data !== rom[0]) begin failures++; $display("FAIL rmid_restart got=%b/%h exp=1/%h", s_valid, s_data, rom[0]); end
        cyc();
        checks++; if (s_fim !== 1'b1 || s_ativo !== 1'b0) begin failures++; $display("FAIL rmid_single got=%b/%b exp=1/0", s_fim, s_ativo); end
    endtask

`ifdef ROUTE_LOOP_EN
    task automatic test_loop();
        logic [DATA_W-1:0] exp;
        logic exp_fim;
        int fims;
        int n;
        s_ready = 1'b1; ultimo = 4'd1; iniciar = 1'b1;
        for (int i = 0; i < 3; i++) begin s_q.push_back(4'h0); s_q.push_back(4'hA); end
        cyc();
        iniciar = 1'b0;
        fims = 0; n = 0;
        while (s_q.size() != 0 && n < 40) begin
            exp_fim = 1'b0;
            if (s_valid) begin
                exp = s_q.pop_front();
                checks++; if (s_data !== exp) begin failures++; $display("FAIL loop_data got=%h exp=%h", s_data, exp); end
                exp_fim = (exp == 4'hA);
            end
            cyc(); n++;
            checks++; if (s_fim !== exp_fim) begin failures++; $display("FAIL loop_fim got=%b exp=%b", s_fim, exp_fim); end
            if (s_fim) fims++;
        end
        checks++; if (fims != 3 || s_ativo !== 1'b1) begin failures++; $display("FAIL loop_passes got=%0d/%b exp=3/1", fims, s_ativo); end
        n = 0; while (!s_valid && n < 10) begin cyc(); n++; end
        parar = 1'b1; s_ready = 1'b0;
        cyc();
        parar = 1'b0;
        checks++; if (s_valid !== 1'b0 || s_ativo !== 1'b0 || s_fim !== 1'b0) begin failures++; $display("FAIL loop_stop got=%b/%b/%b exp=0/0/0", s_valid, s_ativo, s_fim); end
        cyc();
        checks++; if (s_ativo !== 1'b0 || s_fim !== 1'b0) begin failures++; $display("FAIL loop_stay_idle got=%b/%b exp=0/0", s_ativo, s_fim); end
        s_q.delete();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(i ^ 5);
        rom[0] = 4'b0000; rom[1] = 4'b1010; rom[2] = 4'b0010; rom[3] = 4'b0100;
        test_reset();
        test_stream();
        test_stall();
        test_conflict();
        test_r_burst();
        test_reset_mid();
`ifdef ROUTE_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
